// File: rtl/sram_like_pkg.sv
// Shared definitions for the sram-like request arbiter: size codes, id width
// helper and grant FSM state encoding.
package sram_like_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Channel id width; a single channel still needs one bit of storage.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t HOLD = 1'b1;

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// In-order FIFO of issuing channel ids; head names the owner of the next data_ok.
module arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// N-channel to one sram-like port arbiter with in-order response steering.
// Define ARB_RR_EN for round-robin arbitration (default: fixed priority, highest index).
module sram_like_arbiter
  import sram_like_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          ch_req,
  input  logic [NCH-1:0]          ch_wr,
  input  logic [NCH-1:0][1:0]     ch_size,
  input  logic [NCH-1:0][AW-1:0]  ch_addr,
  input  logic [NCH-1:0][DW-1:0]  ch_wdata,
  output logic [NCH-1:0]          ch_addr_ok,
  output logic [NCH-1:0]          ch_data_ok,
  output logic [DW-1:0]           ch_rdata,
  output logic                    req,
  output logic                    wr,
  output logic [1:0]              size,
  output logic [AW-1:0]           addr,
  output logic [DW-1:0]           wdata,
  input  logic                    addr_ok,
  input  logic                    data_ok,
  input  logic [DW-1:0]           rdata
);
  localparam int IDW = id_w(NCH);

  state_t         state;
  logic [IDW-1:0] grant_id, win, sel, head;
  logic           fifo_full, fifo_empty, accept;

`ifdef ARB_RR_EN
  logic [IDW-1:0] last_grant;

  // Scan from last_grant+1 upward; lowest offset overwrites last, so it wins.
  always_comb begin
    int idx;
    idx = 0;
    win = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NCH;
      if (ch_req[idx]) win = IDW'(idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       last_grant <= '0;
    else if (accept) last_grant <= sel;
  end
`else
  always_comb begin
    win = '0;
    for (int i = 0; i < NCH; i++)
      if (ch_req[i]) win = IDW'(i);
  end
`endif

  // A stalled request is pinned to grant_id until the port takes it.
  assign sel    = (state == HOLD) ? grant_id : win;
  assign req    = ch_req[sel] & ~fifo_full;
  assign wr     = ch_wr[sel];
  assign size   = ch_size[sel];
  assign addr   = ch_addr[sel];
  assign wdata  = ch_wdata[sel];
  assign accept = req & addr_ok;

  always_comb begin
    ch_addr_ok      = '0;
    ch_addr_ok[sel] = accept;
  end

  always_comb begin
    ch_data_ok       = '0;
    ch_data_ok[head] = data_ok & ~fifo_empty;
  end

  assign ch_rdata = rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant_id <= '0;
    end else begin
      case (state)
        IDLE: if (req && !addr_ok) begin
          state    <= HOLD;
          grant_id <= win;
        end
        HOLD: if (accept) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  arb_id_fifo #(.DEPTH(OUTSTANDING), .W(IDW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (data_ok),
    .din   (sel),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter (NCH=2, OUTSTANDING=4); works with or without ARB_RR_EN.
module tb_sram_like_arbiter;
  import sram_like_pkg::*;

  localparam int NCH = 2, AW = 32, DW = 32, OUTST = 4;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NCH-1:0]         ch_req, ch_wr, ch_addr_ok, ch_data_ok;
  logic [NCH-1:0][1:0]    ch_size;
  logic [NCH-1:0][AW-1:0] ch_addr;
  logic [NCH-1:0][DW-1:0] ch_wdata;
  logic [DW-1:0]          ch_rdata, wdata, rdata;
  logic                   req, wr, addr_ok, data_ok;
  logic [1:0]             size;
  logic [AW-1:0]          addr;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .OUTSTANDING(OUTST)) dut (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_addr_ok(ch_addr_ok),
    .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata), .req(req), .wr(wr), .size(size),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks happen 1ns later still.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; ch_req = '0; ch_wr = '0; ch_size = '0; ch_addr = '0; ch_wdata = '0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
    tick(); tick();
    reset = 1'b0;
    settle();
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_addr_ok", 64'(ch_addr_ok), 64'd0);
    chk("rst_data_ok", 64'(ch_data_ok), 64'd0);
    chk("rst_count", 64'(dut.u_fifo.count), 64'd0);

    // Single read from ch0 accepted immediately, answered 3 cycles later.
    tick();
    ch_req = 2'b01; ch_addr[0] = 32'h1000; ch_size[0] = SIZE_W; addr_ok = 1'b1;
    settle();
    chk("rd_req", 64'(req), 64'd1);
    chk("rd_addr", 64'(addr), 64'h1000);
    chk("rd_size", 64'(size), 64'(SIZE_W));
    chk("rd_addr_ok", 64'(ch_addr_ok), 64'b01);
    tick();
    ch_req = '0; addr_ok = 1'b0;
    settle();
    chk("rd_count1", 64'(dut.u_fifo.count), 64'd1);
    chk("rd_no_early_data", 64'(ch_data_ok), 64'b00);
    tick(); tick();
    data_ok = 1'b1; rdata = 32'hDEADBEEF;
    settle();
    chk("rd_data_ok", 64'(ch_data_ok), 64'b01);
    chk("rd_rdata", 64'(ch_rdata), 64'hDEADBEEF);
    tick();
    data_ok = 1'b0;
    settle();
    chk("rd_count0", 64'(dut.u_fifo.count), 64'd0);

    // Both channels at once: ch1 first, ch0 next cycle, responses in order.
    tick();
    ch_req = 2'b11; ch_addr[0] = 32'h2000; ch_addr[1] = 32'h3000;
    ch_wr = 2'b10; ch_wdata[1] = 32'hA5A5_0001; addr_ok = 1'b1;
    settle();
    chk("pri_first", 64'(ch_addr_ok), 64'b10);
    chk("pri_addr1", 64'(addr), 64'h3000);
    chk("pri_wr", 64'(wr), 64'd1);
    chk("pri_wdata", 64'(wdata), 64'hA5A5_0001);
    tick();
    ch_req = 2'b01;
    settle();
    chk("pri_second", 64'(ch_addr_ok), 64'b01);
    chk("pri_addr0", 64'(addr), 64'h2000);
    tick();
    ch_req = '0; ch_wr = '0; addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h1;
    settle();
    chk("pri_resp1", 64'(ch_data_ok), 64'b10);
    tick();
    rdata = 32'h2;
    settle();
    chk("pri_resp0", 64'(ch_data_ok), 64'b01);
    tick();
    data_ok = 1'b0;

    // ch1 stalls 2 cycles; ch0 arriving meanwhile must not steal the port.
    ch_req = 2'b10; ch_addr[1] = 32'h4000; ch_addr[0] = 32'h5000;
    settle();
    chk("hold_c0_addr", 64'(addr), 64'h4000);
    chk("hold_c0_ok", 64'(ch_addr_ok), 64'b00);
    tick();
    ch_req = 2'b11;
    settle();
    chk("hold_c1_addr", 64'(addr), 64'h4000);
    chk("hold_c1_ok", 64'(ch_addr_ok), 64'b00);
    tick();
    addr_ok = 1'b1;
    settle();
    chk("hold_c2_addr", 64'(addr), 64'h4000);
    chk("hold_c2_ok", 64'(ch_addr_ok), 64'b10);
    tick();
    ch_req = 2'b01;
    settle();
    chk("hold_ch0_ok", 64'(ch_addr_ok), 64'b01);
    chk("hold_ch0_addr", 64'(addr), 64'h5000);
    tick();
    ch_req = '0; addr_ok = 1'b0; data_ok = 1'b1;
    settle();
    chk("hold_resp1", 64'(ch_data_ok), 64'b10);
    tick();
    settle();
    chk("hold_resp0", 64'(ch_data_ok), 64'b01);
    tick();
    data_ok = 1'b0;
    settle();
    chk("hold_count0", 64'(dut.u_fifo.count), 64'd0);

    // Fill all 4 slots; 5th request blocked even with a same-cycle pop.
    ch_req = 2'b01; ch_addr[0] = 32'h6000; addr_ok = 1'b1;
    for (int i = 0; i < OUTST; i++) begin
      settle();
      chk($sformatf("full_acc%0d", i), 64'(ch_addr_ok), 64'b01);
      tick();
    end
    data_ok = 1'b1;
    settle();
    chk("full_req0", 64'(req), 64'd0);
    chk("full_no_ok", 64'(ch_addr_ok), 64'b00);
    chk("full_pop", 64'(ch_data_ok), 64'b01);
    tick();
    data_ok = 1'b0;
    settle();
    chk("full_req1", 64'(req), 64'd1);
    chk("full_reacc", 64'(ch_addr_ok), 64'b01);
    tick();
    ch_req = '0; addr_ok = 1'b0;
    settle();
    chk("full_count4", 64'(dut.u_fifo.count), 64'd4);
    data_ok = 1'b1;
    for (int i = 0; i < OUTST; i++) begin
      settle();
      chk($sformatf("drain%0d", i), 64'(ch_data_ok), 64'b01);
      tick();
    end

    // Stray response with nothing outstanding is dropped.
    settle();
    chk("stray_ok", 64'(ch_data_ok), 64'b00);
    tick();
    data_ok = 1'b0;
    settle();
    chk("stray_count", 64'(dut.u_fifo.count), 64'd0);

    // Continuous contention: alternate under round-robin, ch1 always otherwise.
    ch_req = 2'b11; addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("stream%0d", i), 64'(ch_addr_ok),
          (RR && (i % 2 == 1)) ? 64'b01 : 64'b10);
      tick();
    end
    reset = 1'b1; addr_ok = 1'b0;
    tick();
    reset = 1'b0; ch_req = '0; data_ok = 1'b1;
    settle();
    chk("mrst_req", 64'(req), 64'd0);
    chk("mrst_count", 64'(dut.u_fifo.count), 64'd0);
    chk("mrst_stale", 64'(ch_data_ok), 64'b00);
    tick();
    data_ok = 1'b0; ch_req = 2'b11; addr_ok = 1'b1;
    settle();
    chk("mrst_grant", 64'(ch_addr_ok), 64'b10);
    tick();
    ch_req = '0; addr_ok = 1'b0;
    tick();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
